// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the BCD scan display: digit width,
// 7-segment decode (gfedcba, bit0 = a) and output polarity.
package seg7_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int MAX_DIGITS = 4;

  function automatic logic [6:0] seg_of(input logic [BCD_W-1:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Common-anode boards want every segment and select line active-low.
  function automatic logic [7:0] to_pins(input logic [7:0] v, input logic inv);
    return inv ? ~v : v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter: up/down stepping with carry/borrow chaining,
// clamped parallel load and synchronous clear.
module bcd_digit
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clear,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             down,
  input  logic             step_in,
  output logic [BCD_W-1:0] value,
  output logic             step_out
);

  logic at_limit;

  assign at_limit = down ? (value == '0) : (value == BCD_MAX);
  assign step_out = step_in & at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (ena) begin
      if (clear) begin
        value <= '0;
      end else if (load) begin
        value <= (load_val > BCD_MAX) ? BCD_MAX : load_val;
      end else if (step_in) begin
        if (down) value <= at_limit ? BCD_MAX : value - 1'b1;
        else      value <= at_limit ? '0 : value + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tt_um_bcd_scan_display.sv
// Tiny Tapeout top: multi-digit BCD up/down counter with a frozen-able shadow
// copy that is time-multiplexed onto one 7-segment display.
module tt_um_bcd_scan_display
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int SCAN_DIV     = 64,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PW = $clog2(PRESCALE);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [1:0]    IDX_LAST  = 2'(DIGITS - 1);
  localparam logic [3:0]    SEL_MASK  = 4'((1 << DIGITS) - 1);
  localparam logic [7:0]    SEG_IDLE  = COMMON_ANODE ? 8'hFF : 8'h00;
  localparam logic [3:0]    SEL_IDLE  = COMMON_ANODE ? 4'hF : 4'h0;

  logic             count_en, down, clear, load, lzb, freeze;
  logic [1:0]       load_idx;
  logic [BCD_W-1:0] load_val;

  assign count_en = ui_in[0];
  assign down     = ui_in[1];
  assign clear    = ui_in[2];
  assign load     = ui_in[3];
  assign load_idx = ui_in[5:4];
  assign lzb      = ui_in[6];
  assign freeze   = ui_in[7];
  assign load_val = uio_in[7:4];

  logic unused_uio;
  assign unused_uio = &{1'b0, uio_in[3:0]};

  logic [PW-1:0]             pre_cnt;
  logic                      pre_term, tick;
  logic [DIGITS:0]           step;
  logic [DIGITS*BCD_W-1:0]   count_val, shadow;
  logic                      wrap_flag;
  logic [SW-1:0]             scan_div;
  logic [1:0]                scan_idx;
  logic [MAX_DIGITS*BCD_W-1:0] shadow_ext;
  logic [MAX_DIGITS-1:0]     blank;
  logic                      zero_above;
  logic [BCD_W-1:0]          cur_digit;
  logic [7:0]                seg_next, sel_pins;
  logic [3:0]                sel_raw;
  logic [7:0]                seg_q;
  logic [3:0]                sel_q;

  assign pre_term = (pre_cnt == PRE_LAST);
  // A load or clear in the same cycle swallows the tick.
  assign tick     = pre_term & count_en & ~clear & ~load;
  assign step[0]  = tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (ena) begin
      if (clear || pre_term) pre_cnt <= '0;
      else                   pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar n = 0; n < DIGITS; n++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .clear    (clear),
      .load     (load && (load_idx == 2'(n))),
      .load_val (load_val),
      .down     (down),
      .step_in  (step[n]),
      .value    (count_val[n*BCD_W +: BCD_W]),
      .step_out (step[n+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_flag <= 1'b0;
      shadow    <= '0;
      scan_div  <= '0;
      scan_idx  <= '0;
    end else if (ena) begin
      if (clear)              wrap_flag <= 1'b0;
      else if (step[DIGITS])  wrap_flag <= 1'b1;
      if (!freeze) shadow <= count_val;
      if (scan_div == SCAN_LAST) begin
        scan_div <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? 2'd0 : scan_idx + 1'b1;
      end else begin
        scan_div <= scan_div + 1'b1;
      end
    end
  end

  assign shadow_ext = (MAX_DIGITS*BCD_W)'(shadow);
  assign cur_digit  = shadow_ext[scan_idx*BCD_W +: BCD_W];

  // A digit blanks only when it and every digit above it read zero.
  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int n = MAX_DIGITS - 1; n >= 0; n--) begin
      zero_above = zero_above & (shadow_ext[n*BCD_W +: BCD_W] == '0);
      if (n > 0) blank[n] = zero_above;
    end
  end

  always_comb begin
    seg_next = 8'h00;
    seg_next[6:0] = (lzb && blank[scan_idx]) ? 7'h00 : seg_of(cur_digit);
    seg_next[7]   = wrap_flag && (scan_idx == 2'd0);
    seg_next      = to_pins(seg_next, COMMON_ANODE);
    sel_raw       = (4'b0001 << scan_idx) & SEL_MASK;
    sel_pins      = to_pins({4'h0, sel_raw}, COMMON_ANODE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_IDLE;
      sel_q <= SEL_IDLE;
    end else if (ena) begin
      seg_q <= seg_next;
      sel_q <= sel_pins[3:0];
    end
  end

  assign uo_out  = seg_q;
  assign uio_out = {4'h0, sel_q};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_bcd_scan_display.sv
// Bench for tt_um_bcd_scan_display: directed steps plus random stimulus, with
// an integer-valued reference model of counter, shadow and scan.
module tb_tt_um_bcd_scan_display;

  localparam int DIG  = 4;
  localparam int PRE  = 4;
  localparam int SCAN = 2;
  localparam int MOD  = 10000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       count_en = 0, down = 0, clear = 0, load = 0, lzb = 0, freeze = 0;
  logic [1:0] load_idx = 0;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] ui_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] ca_uo, ca_uio, ca_oe;

  assign ui_in = {freeze, lzb, load_idx, load, clear, down, count_en};

  always #5 clk = ~clk;

  tt_um_bcd_scan_display #(.DIGITS(DIG), .PRESCALE(PRE), .SCAN_DIV(SCAN), .COMMON_ANODE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  tt_um_bcd_scan_display #(.DIGITS(DIG), .PRESCALE(PRE), .SCAN_DIV(SCAN), .COMMON_ANODE(1'b1)) dut_ca (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(ca_uo),
    .uio_in(uio_in), .uio_out(ca_uio), .uio_oe(ca_oe)
  );

  // ---------------- reference model ----------------
  logic [6:0] lut_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int m_val = 0, m_shadow = 0, m_pre = 0, m_div = 0, m_idx = 0;
  bit m_wrap = 0;
  logic [7:0] m_uo = 8'h00;
  logic [3:0] m_sel = 4'h0;

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int k, od, nv;
    logic tk;
    if (!rst_n) begin
      m_val = 0; m_shadow = 0; m_pre = 0; m_div = 0; m_idx = 0;
      m_wrap = 0; m_uo = 8'h00; m_sel = 4'h0;
    end else if (ena) begin
      od = (m_shadow / p10(m_idx)) % 10;
      m_uo[6:0] = (lzb && m_idx > 0 && (m_shadow / p10(m_idx)) == 0) ? 7'h00 : lut_tbl[od];
      m_uo[7]   = m_wrap && (m_idx == 0);
      m_sel     = 4'(1 << m_idx);
      if (!freeze) m_shadow = m_val;
      if (m_div == SCAN - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % DIG;
      end else begin
        m_div = m_div + 1;
      end
      tk = (m_pre == PRE - 1) && count_en;
      if (clear) begin
        m_val = 0; m_wrap = 0; m_pre = 0;
      end else begin
        m_pre = (m_pre + 1) % PRE;
        if (load) begin
          k  = p10(int'(load_idx));
          od = (m_val / k) % 10;
          nv = (int'(uio_in[7:4]) > 9) ? 9 : int'(uio_in[7:4]);
          m_val = m_val - od * k + nv * k;
        end else if (tk) begin
          if (down) begin
            if (m_val == 0) begin m_val = MOD - 1; m_wrap = 1; end
            else m_val = m_val - 1;
          end else begin
            if (m_val == MOD - 1) begin m_val = 0; m_wrap = 1; end
            else m_val = m_val + 1;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_pins(input string tag);
    chk({tag, "_uo"}, uo_out, m_uo);
    chk({tag, "_uio"}, uio_out, {4'h0, m_sel});
    chk({tag, "_oe"}, uio_oe, 8'h0F);
    chk({tag, "_ca_uo"}, ca_uo, ~m_uo);
    chk({tag, "_ca_uio"}, ca_uio, {4'h0, ~m_sel});
    chk({tag, "_ca_oe"}, ca_oe, 8'h0F);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    #2;
    check_pins(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Waits (bounded) for digit n to be selected, then checks its segments.
  task automatic show_digit(input int n, input logic [6:0] exp, input string tag);
    bit found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      cycle(tag);
      if (uio_out[3:0] == 4'(1 << n)) found = 1;
    end
    chk({tag, "_found"}, {7'h0, found}, 8'h01);
    if (found) chk({tag, "_seg"}, {1'b0, uo_out[6:0]}, {1'b0, exp});
  endtask

  task automatic load_digit(input int idx, input logic [3:0] v);
    load = 1; load_idx = 2'(idx); uio_in = {v, 4'h0};
    cycle("load");
    load = 0;
  endtask

  initial begin
    // Reset state, both polarities.
    #3 rst_n = 0;
    #2;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_ca_uo", ca_uo, 8'hFF);
    chk("rst_ca_uio", ca_uio, 8'h0F);
    run(3, "in_rst");
    rst_n = 1;

    // 40 cycles counting: 10 ticks -> 0010.
    count_en = 1;
    run(40, "count40");
    count_en = 0;
    run(4, "settle1");
    show_digit(0, 7'h3F, "c10_d0");
    show_digit(1, 7'h06, "c10_d1");
    show_digit(2, 7'h3F, "c10_d2");
    show_digit(3, 7'h3F, "c10_d3");

    // Load 9999, one up tick -> 0000 with wrap.
    for (int i = 0; i < DIG; i++) load_digit(i, 4'h9);
    count_en = 1;
    run(PRE, "tick_up");
    count_en = 0;
    run(4, "settle2");
    show_digit(0, 7'h3F, "wrap_d0");
    chk("dp_d0_on", {7'h0, uo_out[7]}, 8'h01);
    show_digit(2, 7'h3F, "wrap_d2");
    chk("dp_d2_off", {7'h0, uo_out[7]}, 8'h00);
    clear = 1;
    cycle("clear");
    clear = 0;
    run(3, "settle3");
    show_digit(0, 7'h3F, "clr_d0");
    chk("dp_clr", {7'h0, uo_out[7]}, 8'h00);

    // Down from 0000 -> 9999, then clamped load.
    down = 1; count_en = 1;
    run(PRE, "tick_dn");
    count_en = 0;
    load_digit(2, 4'hC);
    run(4, "settle4");
    show_digit(2, 7'h6F, "clamp_d2");
    show_digit(1, 7'h6F, "dn_d1");
    show_digit(0, 7'h6F, "dn_d0");
    chk("dp_dn", {7'h0, uo_out[7]}, 8'h01);
    down = 0;

    // Leading-zero blanking.
    clear = 1; cycle("clear2"); clear = 0;
    load_digit(0, 4'h7);
    lzb = 1;
    run(4, "settle5");
    show_digit(3, 7'h00, "lzb_d3");
    show_digit(2, 7'h00, "lzb_d2");
    show_digit(1, 7'h00, "lzb_d1");
    show_digit(0, 7'h07, "lzb_d0");
    clear = 1; cycle("clear3"); clear = 0;
    run(4, "settle6");
    show_digit(0, 7'h3F, "lzb0_d0");
    show_digit(1, 7'h00, "lzb0_d1");
    lzb = 0;

    // Freeze for 20 ticks, then release.
    freeze = 1; count_en = 1;
    run(PRE * 20, "frozen");
    show_digit(1, 7'h3F, "frz_d1");
    freeze = 0; count_en = 0;
    run(4, "unfreeze");
    show_digit(1, 7'h5B, "unfrz_d1");

    // ena low mid-scan: everything holds.
    count_en = 1;
    run(3, "pre_ena");
    ena = 0;
    run(10, "ena_off");
    ena = 1;
    run(8, "ena_on");
    count_en = 0;

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      count_en = ($urandom_range(0, 3) != 0);
      down     = $urandom_range(0, 1);
      clear    = ($urandom_range(0, 31) == 0);
      load     = ($urandom_range(0, 7) == 0);
      load_idx = 2'($urandom_range(0, 3));
      lzb      = $urandom_range(0, 1);
      freeze   = ($urandom_range(0, 3) == 0);
      ena      = ($urandom_range(0, 7) != 0);
      uio_in   = 8'($urandom);
      cycle("rand");
    end
    clear = 0; load = 0; freeze = 0; ena = 1;

    // Async reset while counting.
    count_en = 1;
    run(7, "pre_rst");
    rst_n = 0;
    #1;
    chk("arst_uo", uo_out, 8'h00);
    chk("arst_uio", uio_out, 8'h00);
    chk("arst_ca_uo", ca_uo, 8'hFF);
    chk("arst_ca_uio", ca_uio, 8'h0F);
    run(2, "arst_hold");
    rst_n = 1;
    run(12, "post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tt_um_bcd_scan_display.md
# tt_um_bcd_scan_display

Parametrised multi-digit BCD up/down counter with a time-multiplexed 7-segment display driver, packaged as a Tiny Tapeout user top. It generalises the single-display project to 1–4 digits and adds load, freeze, leading-zero blanking, wrap flagging and anode/cathode polarity selection. It drives the shared `tb` harness pins directly; segments appear on `uo_out[6:0]`.

## Interface
- `DIGITS`, 4: number of BCD digits, 1..4.
- `PRESCALE`, 1000: clock cycles per count tick, ≥2.
- `SCAN_DIV`, 64: clock cycles per digit dwell, ≥2.
- `COMMON_ANODE`, 0: 1 inverts all segment and select outputs (active-low).

- `clk` in 1: single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design selected; low freezes all state.
- `ui_in` in 8: [0] count_en, [1] down, [2] clear, [3] load, [5:4] load_idx, [6] lzb (leading-zero blank), [7] freeze.
- `uo_out` out 8: [6:0] segments gfedcba (bit0 = a), [7] dp.
- `uio_in` in 8: [7:4] load value; [3:0] ignored.
- `uio_out` out 8: [3:0] one-hot digit select (bit n = digit n), [7:4] = 0.
- `uio_oe` out 8: constant 8'h0F.

## Operation
- Prescaler: counts 0..PRESCALE-1 while `ena`; wraps. Tick = terminal count AND count_en.
- Counter: DIGITS decades. Up: digit 9→0 carries. Down: 0→9 borrows. Full wrap (all 9→all 0 up, all 0→all 9 down) sets sticky `wrap_flag`.
- Priority per cycle: clear > load > tick.
  - clear: counter, wrap_flag, prescaler → 0.
  - load: digit[load_idx] ← min(uio_in[7:4], 9); other digits and wrap_flag unchanged; ignored if load_idx ≥ DIGITS. A coincident tick is dropped.
- Shadow register: copies counter every cycle unless freeze=1; counting continues underneath.
- Scan: divider counts 0..SCAN_DIV-1; on terminal, scan_idx advances 0..DIGITS-1 and wraps to 0.
- Digit output: segments = LUT(shadow[scan_idx]); LUT 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
- LZB (lzb=1): digit n>0 blanked (segments 0) if it and all higher digits of shadow are 0. Digit 0 is never blanked.
- dp = wrap_flag AND scan_idx==0.
- Select = one-hot(scan_idx); selects for n ≥ DIGITS always inactive.
- COMMON_ANODE=1: uo_out and uio_out[3:0] bitwise inverted; uio_out[7:4] stay 0.
- ena=0: prescaler, scan, counter, shadow and output registers hold.

## Timing
- Reset (async assert): counter, shadow, prescaler, scan, wrap_flag = 0. uo_out = 8'h00, uio_out = 8'h00 (COMMON_ANODE=1: uo_out = 8'hFF, uio_out = 8'h0F). uio_oe = 8'h0F always.
- Release is synchronous to clk. First output-register load occurs at the first edge after release.
- uo_out and uio_out[3:0] are registered together; they never disagree for a cycle.
- Counter change → shadow +1 cycle → pins +1 cycle (2-cycle latency while that digit is selected).
- First tick occurs PRESCALE cycles after reset release with count_en held high.
- Each digit dwells exactly SCAN_DIV cycles.
- Reset mid-count or mid-scan returns to scan_idx 0 and blank outputs immediately.
- freeze falling: shadow resyncs at the next edge.

## Structure
- Package `seg7_pkg`: BCD_W=4, segment LUT constant/function, polarity helper.
- Sub-module `bcd_digit`: one decade with up/down, carry/borrow in/out, load. Instantiated DIGITS times via generate.
- The top holds the prescaler, scan divider, shadow, LZB logic and output registers.

## Test plan
- Reset, DIGITS=4, PRESCALE=4, SCAN_DIV=2, count_en=1 for 40 cycles → counter 0010; digit0 shows 3F, digit1 shows 06; select cycles 1,2,4,8.
- Load 9 into each digit, then one up tick → 0000; dp lit on digit0 only; clear → dp off.
- down=1 from 0000, one tick → 9999 with wrap_flag=1; load value 0xC to digit 2 → digit 2 reads 9.
- lzb=1, value 0007 → digits 3..1 have segments 0; digit0 shows 07. Value 0000 → digit0 shows 3F.
- freeze=1 for 20 ticks → pins unchanged; release freeze → new value visible 2 cycles later.
- COMMON_ANODE=1 reset → uo_out=FF, uio_out=0F. ena=0 mid-scan → all outputs hold; async reset while counting → outputs reset immediately.
